// File: rtl/cdd_tap_sequencer.sv
// cdd_tap_sequencer
//   Steps a clock-divider delay line one tap at a time and tracks the tap
//   index it believes the line is sitting on.
//
//   Commands (REQ_CMD): 00 LOAD  reload the line to INIT_TAP
//                       01 INC   move up by REQ_ARG taps (clipped at MAX_TAP)
//                       10 DEC   move down by REQ_ARG taps (clipped at 0)
//                       11 SET   move to absolute tap REQ_ARG (clipped at MAX_TAP)
//
//   Handshake: a command is taken on any rising CLK edge where REQ_VALID and
//   REQ_READY are both 1. REQ_READY is high only while idle, so REQ_VALID has
//   no effect at any other time and nothing is queued. Every accepted command
//   ends with exactly one DONE pulse; ERR is meaningful only while DONE=1.
//
//   Ports:
//     CLK, RESETN                 clock, synchronous active-low reset
//     REQ_VALID/REQ_READY         command handshake
//     REQ_CMD[1:0], REQ_ARG[7:0]  command and argument, captured on acceptance
//     DONE, ERR                   completion pulse and clipped/aborted flag
//     TAP_POS[7:0]                tracked tap index
//     DELAY_LINE_LOAD             one-cycle load pulse to the delay line
//     DELAY_LINE_MOVE             one-cycle single-step pulse
//     DELAY_LINE_DIR              step direction (1 = up), stable per command
//     DELAY_LINE_OUT_OF_RANGE     range flag back from the delay line
//     o_dbg_state[2:0]            current FSM state, for observation only
//
//   Move commands spend one EVAL cycle after acceptance so that DIR, which is
//   registered at acceptance, is already settled a full cycle before the
//   first MOVE pulse.
module cdd_tap_sequencer #(
  parameter logic [7:0] MAX_TAP  = 8'd255,
  parameter logic [7:0] INIT_TAP = 8'd1,
  parameter int         MOVE_GAP = 4
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic [1:0] REQ_CMD,
  input  logic [7:0] REQ_ARG,
  output logic       DONE,
  output logic       ERR,
  output logic [7:0] TAP_POS,
  output logic       DELAY_LINE_LOAD,
  output logic       DELAY_LINE_MOVE,
  output logic       DELAY_LINE_DIR,
  input  logic       DELAY_LINE_OUT_OF_RANGE,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_EVAL = 3'd2,
    ST_MOVE = 3'd3,
    ST_GAP  = 3'd4,
    ST_FIN  = 3'd5
  } state_t;

  localparam logic [1:0] CMD_LOAD = 2'b00;
  localparam logic [1:0] CMD_INC  = 2'b01;
  localparam logic [1:0] CMD_DEC  = 2'b10;
  localparam logic [1:0] CMD_SET  = 2'b11;

  // GAP counter runs GAP_LAST..0, so GAP lasts exactly MOVE_GAP cycles.
  localparam logic [3:0] GAP_LAST = 4'(MOVE_GAP - 1);

  state_t     r_state;
  state_t     w_next;

  logic       r_ready_en;  // holds READY low on the first cycle out of reset
  logic [7:0] r_tap;
  logic [7:0] r_cnt;       // steps still to issue
  logic       r_dir;
  logic       r_clip;
  logic       r_abort;
  logic       r_is_load;
  logic       r_oor;       // registered copy of the range flag
  logic [3:0] r_gap;

  logic       w_accept;
  logic       w_gap_last;
  logic       w_abort_now;
  logic       w_dir_new;
  logic       w_clip_new;
  logic [7:0] w_cnt_new;
  logic [7:0] w_head;
  logic [7:0] w_tgt;
  logic [8:0] w_arg9;

  assign w_accept    = (r_state == ST_IDLE) && r_ready_en && REQ_VALID;
  assign w_gap_last  = (r_gap == 4'd0);
  // The range flag only means something after a step; a LOAD never aborts.
  assign w_abort_now = (r_state == ST_GAP) && w_gap_last && r_oor && !r_is_load;
  assign w_head      = MAX_TAP - r_tap;
  // Compared at 9 bits so the clip test stays meaningful when MAX_TAP = 255.
  assign w_arg9      = {1'b0, REQ_ARG};
  assign w_tgt       = (w_arg9 > {1'b0, MAX_TAP}) ? MAX_TAP : REQ_ARG;

  // Step count, clip flag and direction for the command being offered.
  always_comb begin
    w_dir_new  = r_dir;
    w_cnt_new  = 8'd0;
    w_clip_new = 1'b0;
    case (REQ_CMD)
      CMD_INC: begin
        w_dir_new = 1'b1;
        if (REQ_ARG > w_head) begin
          w_cnt_new  = w_head;
          w_clip_new = 1'b1;
        end else begin
          w_cnt_new  = REQ_ARG;
        end
      end
      CMD_DEC: begin
        w_dir_new = 1'b0;
        if (REQ_ARG > r_tap) begin
          w_cnt_new  = r_tap;
          w_clip_new = 1'b1;
        end else begin
          w_cnt_new  = REQ_ARG;
        end
      end
      CMD_SET: begin
        w_dir_new  = (REQ_ARG > r_tap);
        w_clip_new = (w_arg9 > {1'b0, MAX_TAP});
        w_cnt_new  = (w_tgt > r_tap) ? (w_tgt - r_tap) : (r_tap - w_tgt);
      end
      default: begin
        w_dir_new  = r_dir;
      end
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = (REQ_CMD == CMD_LOAD) ? ST_LOAD : ST_EVAL;
        end
      end
      ST_LOAD: w_next = ST_GAP;
      ST_EVAL: w_next = (r_cnt == 8'd0) ? ST_FIN : ST_MOVE;
      ST_MOVE: w_next = ST_GAP;
      ST_GAP: begin
        if (w_gap_last) begin
          w_next = (w_abort_now || (r_cnt == 8'd0)) ? ST_FIN : ST_MOVE;
        end
      end
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath: command capture, tap tracking, step and gap counters
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_ready_en <= 1'b0;
      r_tap      <= INIT_TAP;
      r_cnt      <= 8'd0;
      r_dir      <= 1'b0;
      r_clip     <= 1'b0;
      r_abort    <= 1'b0;
      r_is_load  <= 1'b0;
      r_oor      <= 1'b0;
      r_gap      <= 4'd0;
    end else begin
      r_ready_en <= 1'b1;
      r_oor      <= DELAY_LINE_OUT_OF_RANGE;
      if (w_accept) begin
        r_dir     <= w_dir_new;
        r_cnt     <= w_cnt_new;
        r_clip    <= w_clip_new;
        r_abort   <= 1'b0;
        r_is_load <= (REQ_CMD == CMD_LOAD);
      end
      case (r_state)
        ST_LOAD: begin
          r_tap <= INIT_TAP;
          r_gap <= GAP_LAST;
        end
        ST_MOVE: begin
          r_tap <= r_dir ? (r_tap + 8'd1) : (r_tap - 8'd1);
          r_cnt <= r_cnt - 8'd1;
          r_gap <= GAP_LAST;
        end
        ST_GAP: begin
          if (!w_gap_last) begin
            r_gap <= r_gap - 4'd1;
          end else if (w_abort_now) begin
            // The step just issued did not land: undo it.
            r_tap   <= r_dir ? (r_tap - 8'd1) : (r_tap + 8'd1);
            r_abort <= 1'b1;
          end
        end
        default: begin
          r_gap <= r_gap;
        end
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    REQ_READY       = (r_state == ST_IDLE) && r_ready_en;
    DELAY_LINE_LOAD = (r_state == ST_LOAD);
    DELAY_LINE_MOVE = (r_state == ST_MOVE);
    DONE            = (r_state == ST_FIN);
    ERR             = (r_state == ST_FIN) && (r_clip || r_abort);
  end

  assign TAP_POS        = r_tap;
  assign DELAY_LINE_DIR = r_dir;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_cdd_tap_sequencer.sv
// Bench for cdd_tap_sequencer. MAX_TAP is lowered to 40 so that the clip
// paths of INC and SET are reachable with short runs; INIT_TAP and MOVE_GAP
// keep their defaults (1 and 4, so one step takes 5 cycles).
// All sampling and driving happens on the falling edge of CLK.
// Latencies are counted in cycles after the accepting edge: cycle 1 is the
// cycle that begins at that edge.
module tb_cdd_tap_sequencer;

  localparam logic [7:0] P_MAX  = 8'd40;
  localparam logic [7:0] P_INIT = 8'd1;
  localparam int         P_GAP  = 4;
  localparam int         BUDGET = 400;

  localparam logic [1:0] C_LOAD = 2'b00;
  localparam logic [1:0] C_INC  = 2'b01;
  localparam logic [1:0] C_DEC  = 2'b10;
  localparam logic [1:0] C_SET  = 2'b11;

  logic       CLK;
  logic       RESETN;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic [1:0] REQ_CMD;
  logic [7:0] REQ_ARG;
  logic       DONE;
  logic       ERR;
  logic [7:0] TAP_POS;
  logic       DELAY_LINE_LOAD;
  logic       DELAY_LINE_MOVE;
  logic       DELAY_LINE_DIR;
  logic       DELAY_LINE_OUT_OF_RANGE;
  logic [2:0] dbg_state;

  int errors = 0;
  int checks = 0;

  // Observations from the last command
  int         obs_moves, obs_loads, obs_lat, obs_dir_bad, obs_timeout;
  logic       obs_err, obs_dir0, obs_ready_after, obs_done_after;
  logic [7:0] obs_final;
  logic [7:0] obs_q[$];
  int         obs_move_c[$];

  // Reference model state and expectations
  int         m_tap;
  int         exp_moves, exp_loads, exp_lat, exp_final;
  logic       exp_err, exp_dir;
  logic [7:0] exp_q[$];

  cdd_tap_sequencer #(
    .MAX_TAP  (P_MAX),
    .INIT_TAP (P_INIT),
    .MOVE_GAP (P_GAP)
  ) dut (
    .CLK                     (CLK),
    .RESETN                  (RESETN),
    .REQ_VALID               (REQ_VALID),
    .REQ_READY               (REQ_READY),
    .REQ_CMD                 (REQ_CMD),
    .REQ_ARG                 (REQ_ARG),
    .DONE                    (DONE),
    .ERR                     (ERR),
    .TAP_POS                 (TAP_POS),
    .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
    .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
    .DELAY_LINE_DIR          (DELAY_LINE_DIR),
    .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE),
    .o_dbg_state             (dbg_state)
  );

  // Clock and global time limit
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Reference model: tap arithmetic straight from the command rules.
  task automatic model_cmd(input logic [1:0] cmd, input logic [7:0] arg, input int oor_after);
    int tgt, steps, sgn;
    exp_q.delete();
    exp_loads = 0;
    exp_err   = 1'b0;
    exp_dir   = 1'b0;
    if (cmd == C_LOAD) begin
      exp_loads = 1;
      exp_moves = 0;
      exp_final = int'(P_INIT);
      exp_lat   = 1 + P_GAP + 1;
      m_tap     = exp_final;
      return;
    end
    if (cmd == C_INC) begin
      tgt = m_tap + int'(arg);
      if (tgt > int'(P_MAX)) begin tgt = int'(P_MAX); exp_err = 1'b1; end
      exp_dir = 1'b1;
    end else if (cmd == C_DEC) begin
      tgt = m_tap - int'(arg);
      if (tgt < 0) begin tgt = 0; exp_err = 1'b1; end
      exp_dir = 1'b0;
    end else begin
      tgt = int'(arg);
      if (tgt > int'(P_MAX)) begin tgt = int'(P_MAX); exp_err = 1'b1; end
      exp_dir = (int'(arg) > m_tap);
    end
    steps     = (tgt > m_tap) ? tgt - m_tap : m_tap - tgt;
    sgn       = (tgt > m_tap) ? 1 : -1;
    exp_moves = steps;
    exp_final = tgt;
    if (oor_after != 0 && oor_after <= steps) begin
      exp_moves = oor_after;
      exp_err   = 1'b1;
      exp_final = m_tap + sgn * (oor_after - 1);
    end
    for (int k = 1; k <= exp_moves; k++) exp_q.push_back(8'(m_tap + sgn * k));
    exp_lat = (exp_moves == 0) ? 2 : 2 + exp_moves * (1 + P_GAP);
    m_tap   = exp_final;
  endtask

  // Driver + monitor for one command. Called and returns on a falling edge.
  // oor_after: raise OUT_OF_RANGE right after that many MOVE pulses (0 = never).
  // hold_valid: keep REQ_VALID high (with a LOAD on the bus) until DONE.
  task automatic run_cmd(input logic [1:0] cmd, input logic [7:0] arg,
                         input int oor_after, input bit hold_valid);
    int  wait_n;
    bit  pend;
    obs_moves = 0; obs_loads = 0; obs_lat = -1; obs_dir_bad = 0; obs_timeout = 0;
    obs_err = 1'b0; obs_dir0 = 1'b0; obs_ready_after = 1'b0; obs_done_after = 1'b0;
    obs_final = 8'd0;
    obs_q.delete();
    obs_move_c.delete();
    wait_n = 0;
    while (REQ_READY !== 1'b1 && wait_n < 20) begin
      @(negedge CLK);
      wait_n++;
    end
    if (REQ_READY !== 1'b1) begin
      obs_timeout = 1;
      return;
    end
    REQ_VALID = 1'b1;
    REQ_CMD   = cmd;
    REQ_ARG   = arg;
    @(negedge CLK);
    if (hold_valid) begin
      REQ_CMD = C_LOAD;
      REQ_ARG = 8'hAA;
    end else begin
      REQ_VALID = 1'b0;
    end
    pend = 0;
    for (int c = 1; c <= BUDGET; c++) begin
      if (c > 1) @(negedge CLK);
      if (c == 1) obs_dir0 = DELAY_LINE_DIR;
      else if (DELAY_LINE_DIR !== obs_dir0) obs_dir_bad++;
      if (pend) begin
        obs_q.push_back(TAP_POS);
        pend = 0;
      end
      if (DELAY_LINE_LOAD === 1'b1) obs_loads++;
      if (DELAY_LINE_MOVE === 1'b1) begin
        obs_moves++;
        obs_move_c.push_back(c);
        pend = 1;
        if (oor_after != 0 && obs_moves == oor_after) DELAY_LINE_OUT_OF_RANGE = 1'b1;
      end
      if (DONE === 1'b1) begin
        obs_lat   = c;
        obs_err   = ERR;
        obs_final = TAP_POS;
        break;
      end
    end
    REQ_VALID = 1'b0;
    DELAY_LINE_OUT_OF_RANGE = 1'b0;
    if (obs_lat < 0) begin
      obs_timeout = 1;
    end else begin
      @(negedge CLK);
      obs_done_after  = DONE;
      obs_ready_after = REQ_READY;
    end
  endtask

  task automatic test_reset();
    RESETN = 1'b0; REQ_VALID = 1'b0; REQ_CMD = 2'b00; REQ_ARG = 8'd0;
    DELAY_LINE_OUT_OF_RANGE = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (REQ_READY !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", REQ_READY); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", DONE); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", ERR); end
    checks++; if (DELAY_LINE_LOAD !== 1'b0) begin errors++; $display("FAIL rst_load: got %b want 0", DELAY_LINE_LOAD); end
    checks++; if (DELAY_LINE_MOVE !== 1'b0) begin errors++; $display("FAIL rst_move: got %b want 0", DELAY_LINE_MOVE); end
    checks++; if (DELAY_LINE_DIR !== 1'b0) begin errors++; $display("FAIL rst_dir: got %b want 0", DELAY_LINE_DIR); end
    checks++; if (TAP_POS !== P_INIT) begin errors++; $display("FAIL rst_tap: got %0d want %0d", TAP_POS, P_INIT); end
    RESETN = 1'b1;
    @(negedge CLK);
    checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL rst_ready_rise: got %b want 1", REQ_READY); end
  endtask

  task automatic test_load();
    run_cmd(C_LOAD, 8'd77, 0, 0);
    checks++; if (obs_timeout !== 0) begin errors++; $display("FAIL load_timeout: got %0d want 0", obs_timeout); end
    checks++; if (obs_loads !== 1) begin errors++; $display("FAIL load_pulses: got %0d want 1", obs_loads); end
    checks++; if (obs_moves !== 0) begin errors++; $display("FAIL load_moves: got %0d want 0", obs_moves); end
    checks++; if (obs_lat !== 1 + P_GAP + 1) begin errors++; $display("FAIL load_lat: got %0d want %0d", obs_lat, 1 + P_GAP + 1); end
    checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL load_err: got %b want 0", obs_err); end
    checks++; if (obs_final !== 8'd1) begin errors++; $display("FAIL load_tap: got %0d want 1", obs_final); end
    checks++; if (obs_done_after !== 1'b0) begin errors++; $display("FAIL load_done_width: got %b want 0", obs_done_after); end
    checks++; if (obs_ready_after !== 1'b1) begin errors++; $display("FAIL load_ready_back: got %b want 1", obs_ready_after); end
  endtask

  task automatic test_inc();
    int sp_bad;
    run_cmd(C_INC, 8'd3, 0, 0);
    sp_bad = 0;
    for (int k = 1; k < obs_move_c.size(); k++)
      if (obs_move_c[k] - obs_move_c[k-1] != 1 + P_GAP) sp_bad++;
    checks++; if (obs_moves !== 3) begin errors++; $display("FAIL inc_moves: got %0d want 3", obs_moves); end
    checks++; if (sp_bad !== 0) begin errors++; $display("FAIL inc_spacing: got %0d bad gaps want 0", sp_bad); end
    checks++; if (obs_dir0 !== 1'b1) begin errors++; $display("FAIL inc_dir: got %b want 1", obs_dir0); end
    checks++; if (obs_dir_bad !== 0) begin errors++; $display("FAIL inc_dir_stable: got %0d changes want 0", obs_dir_bad); end
    checks++; if (obs_final !== 8'd4) begin errors++; $display("FAIL inc_tap: got %0d want 4", obs_final); end
    checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL inc_err: got %b want 0", obs_err); end
  endtask

  task automatic test_dec_clip();
    run_cmd(C_DEC, 8'd10, 0, 0);
    checks++; if (obs_moves !== 4) begin errors++; $display("FAIL dec_moves: got %0d want 4", obs_moves); end
    checks++; if (obs_dir0 !== 1'b0) begin errors++; $display("FAIL dec_dir: got %b want 0", obs_dir0); end
    checks++; if (obs_final !== 8'd0) begin errors++; $display("FAIL dec_tap: got %0d want 0", obs_final); end
    checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL dec_err: got %b want 1", obs_err); end
  endtask

  task automatic test_set_zero();
    run_cmd(C_SET, 8'd9, 0, 0);
    checks++; if (obs_final !== 8'd9) begin errors++; $display("FAIL set9_tap: got %0d want 9", obs_final); end
    run_cmd(C_SET, 8'd9, 0, 0);
    checks++; if (obs_moves !== 0) begin errors++; $display("FAIL set0_moves: got %0d want 0", obs_moves); end
    checks++; if (obs_lat !== 2) begin errors++; $display("FAIL set0_lat: got %0d want 2", obs_lat); end
    checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL set0_err: got %b want 0", obs_err); end
    checks++; if (obs_final !== 8'd9) begin errors++; $display("FAIL set0_tap: got %0d want 9", obs_final); end
  endtask

  task automatic test_set_abort();
    run_cmd(C_SET, 8'd2, 0, 0);
    checks++; if (obs_final !== 8'd2) begin errors++; $display("FAIL set2_tap: got %0d want 2", obs_final); end
    run_cmd(C_SET, 8'd20, 3, 0);
    checks++; if (obs_moves !== 3) begin errors++; $display("FAIL abort_moves: got %0d want 3", obs_moves); end
    checks++; if (obs_final !== 8'd4) begin errors++; $display("FAIL abort_tap: got %0d want 4", obs_final); end
    checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL abort_err: got %b want 1", obs_err); end
    checks++; if (obs_ready_after !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", obs_ready_after); end
  endtask

  task automatic test_ignore_valid();
    run_cmd(C_INC, 8'd2, 0, 1);
    checks++; if (obs_moves !== 2) begin errors++; $display("FAIL busy_moves: got %0d want 2", obs_moves); end
    checks++; if (obs_loads !== 0) begin errors++; $display("FAIL busy_loads: got %0d want 0", obs_loads); end
    checks++; if (obs_final !== 8'd6) begin errors++; $display("FAIL busy_tap: got %0d want 6", obs_final); end
    checks++; if (obs_ready_after !== 1'b1) begin errors++; $display("FAIL busy_ready: got %b want 1", obs_ready_after); end
  endtask

  task automatic test_mid_reset();
    int n, w, dones;
    w = 0;
    while (REQ_READY !== 1'b1 && w < 20) begin @(negedge CLK); w++; end
    REQ_VALID = 1'b1; REQ_CMD = C_INC; REQ_ARG = 8'd5;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    n = 0;
    for (int c = 0; c < 60 && n < 2; c++) begin
      @(negedge CLK);
      if (DELAY_LINE_MOVE === 1'b1) n++;
    end
    checks++; if (n !== 2) begin errors++; $display("FAIL mrst_second_move: got %0d moves want 2", n); end
    @(negedge CLK);
    RESETN = 1'b0;
    @(negedge CLK);
    checks++; if (DELAY_LINE_MOVE !== 1'b0) begin errors++; $display("FAIL mrst_move: got %b want 0", DELAY_LINE_MOVE); end
    checks++; if (DELAY_LINE_LOAD !== 1'b0) begin errors++; $display("FAIL mrst_load: got %b want 0", DELAY_LINE_LOAD); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL mrst_done: got %b want 0", DONE); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL mrst_err: got %b want 0", ERR); end
    checks++; if (DELAY_LINE_DIR !== 1'b0) begin errors++; $display("FAIL mrst_dir: got %b want 0", DELAY_LINE_DIR); end
    checks++; if (REQ_READY !== 1'b0) begin errors++; $display("FAIL mrst_ready: got %b want 0", REQ_READY); end
    checks++; if (TAP_POS !== P_INIT) begin errors++; $display("FAIL mrst_tap: got %0d want %0d", TAP_POS, P_INIT); end
    RESETN = 1'b1;
    dones = 0;
    repeat (30) begin
      @(negedge CLK);
      if (DONE === 1'b1) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL mrst_no_done: got %0d pulses want 0", dones); end
    m_tap = int'(P_INIT);
  endtask

  task automatic test_random();
    logic [1:0] cmd;
    logic [7:0] arg;
    int         oor, sp_bad, q_bad;
    bit         hold;
    for (int t = 0; t < 40; t++) begin
      cmd  = 2'($urandom_range(0, 3));
      arg  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 8)) : 8'($urandom_range(0, 60));
      oor  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0;
      hold = ($urandom_range(0, 3) == 0);
      model_cmd(cmd, arg, oor);
      run_cmd(cmd, arg, oor, hold);
      sp_bad = 0;
      for (int k = 0; k < obs_move_c.size(); k++)
        if (obs_move_c[k] != 2 + k * (1 + P_GAP)) sp_bad++;
      q_bad = (obs_q.size() != exp_q.size()) ? 1 : 0;
      for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++)
        if (obs_q[k] !== exp_q[k]) q_bad++;
      checks++; if (obs_timeout !== 0) begin errors++; $display("FAIL rnd%0d_timeout: cmd %0d arg %0d got %0d want 0", t, cmd, arg, obs_timeout); end
      checks++; if (obs_moves !== exp_moves) begin errors++; $display("FAIL rnd%0d_moves: cmd %0d arg %0d got %0d want %0d", t, cmd, arg, obs_moves, exp_moves); end
      checks++; if (obs_loads !== exp_loads) begin errors++; $display("FAIL rnd%0d_loads: got %0d want %0d", t, obs_loads, exp_loads); end
      checks++; if (obs_lat !== exp_lat) begin errors++; $display("FAIL rnd%0d_lat: cmd %0d arg %0d got %0d want %0d", t, cmd, arg, obs_lat, exp_lat); end
      checks++; if (obs_err !== exp_err) begin errors++; $display("FAIL rnd%0d_err: cmd %0d arg %0d got %b want %b", t, cmd, arg, obs_err, exp_err); end
      checks++; if (obs_final !== 8'(exp_final)) begin errors++; $display("FAIL rnd%0d_tap: cmd %0d arg %0d got %0d want %0d", t, cmd, arg, obs_final, exp_final); end
      checks++; if (sp_bad !== 0) begin errors++; $display("FAIL rnd%0d_spacing: got %0d misplaced moves want 0", t, sp_bad); end
      checks++; if (q_bad !== 0) begin errors++; $display("FAIL rnd%0d_step_taps: got %0d differences want 0", t, q_bad); end
      checks++; if (obs_dir_bad !== 0) begin errors++; $display("FAIL rnd%0d_dir_stable: got %0d changes want 0", t, obs_dir_bad); end
      if (cmd != C_LOAD) begin
        checks++; if (obs_dir0 !== exp_dir) begin errors++; $display("FAIL rnd%0d_dir: got %b want %b", t, obs_dir0, exp_dir); end
      end
      checks++; if (obs_ready_after !== 1'b1) begin errors++; $display("FAIL rnd%0d_ready_back: got %b want 1", t, obs_ready_after); end
    end
  endtask

  initial begin
    m_tap = int'(P_INIT);
    test_reset();
    test_load();
    test_inc();
    test_dec_clip();
    test_set_zero();
    test_set_abort();
    test_ignore_valid();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
